// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR word generator with a valid/ready output stage,
// run-time seeding with zero-seed lockup recovery, and an accepted-word counter.
module lfsr_gen #(
  parameter int unsigned     WIDTH  = 32,
  parameter logic [WIDTH-1:0] TAPS  = 'h088C_8892,
  parameter logic [WIDTH-1:0] SEED  = 'd123456789,
  parameter int unsigned     STEPS  = 1,
  parameter int unsigned     GALOIS = 0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             lockup_o,
  output logic [15:0]      word_cnt_o
);

  if (SEED == '0) begin : g_seed_chk
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (WIDTH < 8 || WIDTH > 64) begin : g_width_chk
    $error("lfsr_gen: WIDTH must be in 8..64");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_steps_chk
    $error("lfsr_gen: STEPS must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] stepped;
  logic             handshake, slot_free, advance;

  function automatic logic [WIDTH-1:0] step_once(input logic [WIDTH-1:0] s);
    if (GALOIS != 0) begin
      return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS);
    end
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // All STEPS single steps unrolled into one combinational advance.
  always_comb begin
    stepped = state_q;
    for (int i = 0; i < int'(STEPS); i++) begin
      stepped = step_once(stepped);
    end
  end

  assign handshake = valid_q & out_ready_i;
  assign slot_free = ~valid_q | out_ready_i;
  assign advance   = en_i & slot_free & ~seed_valid_i;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    lockup_d = 1'b0;
    cnt_d    = handshake ? cnt_q + 16'd1 : cnt_q;
    if (seed_valid_i) begin
      // A zero seed would freeze the register, so fall back to SEED and flag it.
      state_d  = (seed_i == '0) ? SEED : seed_i;
      lockup_d = (seed_i == '0);
      valid_d  = 1'b0;
    end else if (advance) begin
      state_d = stepped;
      data_d  = stepped;
      valid_d = 1'b1;
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= SEED;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign lockup_o    = lockup_q;
  assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed checks on a default lfsr_gen plus a randomized run of a STEPS=4 Galois build
// against a behavioural word-sequence model.
module tb_lfsr_gen;

  localparam logic [31:0] Taps = 32'h088C_8892;
  localparam logic [31:0] Seed = 32'd123456789;
  localparam logic [31:0] W1   = 32'h0EB7_9A2A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en_a, sv_a, rdy_a;
  logic [31:0] seed_a;
  logic        vld_a, lock_a;
  logic [31:0] data_a;
  logic [15:0] cnt_a;
  logic        en_b, rdy_b;
  logic        vld_b, lock_b;
  logic [31:0] data_b;
  logic [15:0] cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_gen u_dut_a (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .en_i        (en_a),
    .seed_valid_i(sv_a),
    .seed_i      (seed_a),
    .out_valid_o (vld_a),
    .out_ready_i (rdy_a),
    .out_data_o  (data_a),
    .lockup_o    (lock_a),
    .word_cnt_o  (cnt_a)
  );

  lfsr_gen #(.STEPS(4), .GALOIS(1)) u_dut_b (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .en_i        (en_b),
    .seed_valid_i(1'b0),
    .seed_i      (32'h0),
    .out_valid_o (vld_b),
    .out_ready_i (rdy_b),
    .out_data_o  (data_b),
    .lockup_o    (lock_b),
    .word_cnt_o  (cnt_b)
  );

  // Reference: shift left, feedback is the tap parity (Fibonacci) or a tap XOR on MSB out.
  function automatic logic [31:0] fib_step(input logic [31:0] s);
    return (s << 1) | 32'($countones(s & Taps) % 2);
  endfunction

  function automatic logic [31:0] gal_step4(input logic [31:0] s);
    logic [31:0] r = s;
    for (int i = 0; i < 4; i++) r = r[31] ? ((r << 1) ^ Taps) : (r << 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] model, hold;
    int          accepted, cycles;
    logic        hs, held;

    reset_n = 1'b0; en_a = 0; sv_a = 0; rdy_a = 0; seed_a = '0; en_b = 0; rdy_b = 0;
    tick();
    check("rst_valid", 64'(vld_a), 64'd0);
    check("rst_data", 64'(data_a), 64'd0);
    check("rst_lockup", 64'(lock_a), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);

    // First word, then hold under backpressure.
    reset_n = 1'b1; en_a = 1; rdy_a = 0;
    tick();
    check("first_valid", 64'(vld_a), 64'd1);
    check("first_data", 64'(data_a), 64'(W1));
    check("first_model", 64'(fib_step(Seed)), 64'(data_a));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", 64'(data_a), 64'(W1));
      check("hold_valid", 64'(vld_a), 64'd1);
    end
    check("hold_cnt", 64'(cnt_a), 64'd0);
    rdy_a = 1;
    tick();
    check("b2b_data", 64'(data_a), 64'(fib_step(W1)));
    check("b2b_cnt", 64'(cnt_a), 64'd1);
    en_a = 0;
    tick();
    check("drain_valid", 64'(vld_a), 64'd0);
    check("drain_cnt", 64'(cnt_a), 64'd2);

    // Zero seed: lockup pulse and recovery to SEED.
    sv_a = 1; seed_a = '0; en_a = 1;
    tick();
    check("zseed_lockup", 64'(lock_a), 64'd1);
    check("zseed_valid", 64'(vld_a), 64'd0);
    sv_a = 0; rdy_a = 0;
    tick();
    check("zseed_pulse_end", 64'(lock_a), 64'd0);
    check("zseed_data", 64'(data_a), 64'(W1));

    // Seed load wins over en_i; a concurrent handshake is still counted.
    sv_a = 1; seed_a = 32'h1; rdy_a = 1;
    tick();
    check("seed_valid", 64'(vld_a), 64'd0);
    check("seed_cnt", 64'(cnt_a), 64'd3);
    check("seed_lockup", 64'(lock_a), 64'd0);
    sv_a = 0; rdy_a = 0;
    tick();
    check("seed1_data", 64'(data_a), 64'h2);

    // Reset with a pending word drops it.
    reset_n = 1'b0;
    tick();
    check("mrst_valid", 64'(vld_a), 64'd0);
    check("mrst_cnt", 64'(cnt_a), 64'd0);
    reset_n = 1'b1;
    tick();
    check("mrst_data", 64'(data_a), 64'(W1));
    en_a = 0;

    // Randomized run on the STEPS=4 Galois build.
    model = Seed; accepted = 0; cycles = 0; hold = '0; held = 0;
    while (accepted < 10000 && cycles < 60000) begin
      en_b  = ($urandom % 8) != 0;
      rdy_b = ($urandom % 4) != 0;
      hs    = vld_b && rdy_b;
      if (hs) begin
        model = gal_step4(model);
        check("rand_word", 64'(data_b), 64'(model));
        accepted++;
      end
      held = vld_b && !rdy_b;
      hold = data_b;
      tick();
      cycles++;
      if (held) check("rand_hold", 64'(data_b), 64'(hold));
      if (cycles % 64 == 0) check("rand_cnt", 64'(cnt_b), 64'(accepted[15:0]));
    end
    check("rand_accepted", 64'(accepted), 64'd10000);
    en_b = 0; rdy_b = 0;
    tick();
    check("rand_final_cnt", 64'(cnt_b), 64'(accepted[15:0]));
    check("rand_lockup", 64'(lock_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32: state/output width, 8..64.
REQ-002 SHALL have parameter TAPS, default 32'h088C_8892: WIDTH-bit feedback mask (bit n set = state bit n taps).
REQ-003 SHALL have parameter SEED, default 32'd123456789: reset/recovery state; nonzero, else elaboration error.
REQ-004 SHALL have parameter STEPS, default 1: LFSR steps per advance, 1..WIDTH.
REQ-005 SHALL have parameter GALOIS, default 0: 0 = Fibonacci update, 1 = Galois update.
REQ-006 clk_i  input  1  sole clock, all state on rising edge.
REQ-007 reset_ni  input  1  synchronous, active-low reset.
REQ-008 en_i  input  1  request one advance (STEPS steps) this cycle.
REQ-009 seed_valid_i  input  1  load seed_i this cycle.
REQ-010 seed_i  input  WIDTH  seed value.
REQ-011 out_valid_o  output  1  out_data_o holds an unconsumed word.
REQ-012 out_ready_i  input  1  consumer accepts word when out_valid_o=1.
REQ-013 out_data_o  output  WIDTH  registered generated word.
REQ-014 lockup_o  output  1  one-cycle pulse: zero seed replaced by SEED.
REQ-015 word_cnt_o  output  16  count of accepted words, wraps 16'hFFFF->0.

Function
REQ-016 Fibonacci single step SHALL be next = {s[WIDTH-2:0], ^(s & TAPS)}.
REQ-017 Galois single step SHALL be next = {s[WIDTH-2:0],1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS).
REQ-018 One advance SHALL apply STEPS single steps combinationally within one cycle (no multicycle latency).
REQ-019 Slot free = !out_valid_o || out_ready_i; an advance SHALL occur when en_i=1, slot free, seed_valid_i=0.
REQ-020 On advance: state <= stepped value; out_data_o <= stepped value; out_valid_o <= 1, all visible the next cycle.
REQ-021 Handshake (out_valid_o && out_ready_i) without advance SHALL clear out_valid_o next cycle.
REQ-022 While out_valid_o=1 and out_ready_i=0: state, out_data_o, out_valid_o SHALL hold regardless of en_i.
REQ-023 Handshake and advance in the same cycle SHALL deliver back-to-back words at one per cycle.
REQ-024 seed_valid_i=1 SHALL take priority over en_i: state <= seed_i, out_valid_o <= 0, pending word dropped, not counted.
REQ-025 seed_i == 0 SHALL load SEED instead and pulse lockup_o for exactly one cycle.
REQ-026 word_cnt_o SHALL increment by 1 on each handshake, including a handshake in the same cycle as a seed load.
REQ-027 en_i with STEPS=k SHALL equal k successive STEPS=1 advances in produced state.

Reset
REQ-028 reset_ni=0 at a clock edge SHALL set state=SEED, out_data_o=0, out_valid_o=0, lockup_o=0, word_cnt_o=0; priority over all inputs.
REQ-029 Reset mid-stream SHALL drop any pending word without counting it; the first advance after release SHALL yield step(SEED).
REQ-030 No output SHALL change except at rising clk_i (no asynchronous path from reset_ni).

Verification
REQ-031 Defaults, reset then en_i=1, out_ready_i=1 for one cycle -> out_valid_o=1, out_data_o=32'h0EB7_9A2A, word_cnt_o=1 after accept.
REQ-032 out_ready_i=0 for 5 cycles with en_i=1 -> out_data_o stable at 32'h0EB7_9A2A, state unchanged; on ready=1, next cycle output = step(32'h0EB7_9A2A).
REQ-033 seed_valid_i=1, seed_i=0 -> lockup_o=1 one cycle, out_valid_o=0, next advance yields 32'h0EB7_9A2A.
REQ-034 seed_valid_i=1 and en_i=1 same cycle, seed_i=32'h0000_0001 -> state 1, out_valid_o=0; next advance yields 32'h0000_0002.
REQ-035 STEPS=4 and GALOIS=1 builds vs. reference model over 10000 advances with random ready -> bit-exact words, no drops or duplicates.
REQ-036 reset_ni=0 for one cycle while out_valid_o=1, ready=0 -> out_valid_o=0, word_cnt_o=0; first subsequent word = 32'h0EB7_9A2A.
